data_ram: RTL

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/data_ram.sv
// Word-organised data RAM with byte/half/word lanes, alignment checking
// and an optional fixed number of wait cycles after every access.
module data_ram #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ram_address,
    input  logic        ram_enable,
    input  logic [31:0] ram_write_data,
    input  logic        ram_write_enable,
    input  logic [2:0]  ram_write_mode,
    input  logic        ram_read_enable,
    input  logic [2:0]  ram_read_mode,
    output logic [31:0] ram_read_data,
    output logic        ram_wait,
    output logic        misaligned
);

    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT4 = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic [31:0]        r_rd_data;
    logic               r_mis;
    logic [31:0]        r_mem [0:DEPTH-1];

    logic               w_capture;
    logic [1:0]         w_lane;
    logic [ADDR_BITS-1:0] w_idx;
    logic               w_is_wr;
    logic               w_is_rd;
    logic               w_access;
    logic               w_bad;

    logic               w_wr_ok;
    logic [3:0]         w_wr_be;
    logic [31:0]        w_wr_data;

    logic               w_rd_ok;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_rd_shift;
    logic [31:0]        w_rd_val;
    logic [31:0]        w_rd_nxt;
    logic               w_unused;

    // Upper address bits alias onto the array.
    assign w_unused  = ^ram_address[31:ADDR_BITS+2];

    assign w_capture = ram_enable && (r_state == IDLE);
    assign w_lane    = ram_address[1:0];
    assign w_idx     = ram_address[ADDR_BITS+1:2];
    assign w_is_wr   = ram_write_enable;
    assign w_is_rd   = ram_read_enable && !ram_write_enable;
    assign w_access  = ram_write_enable || ram_read_enable;

    // Store: replicate the datum across lanes and let byte enables pick.
    always_comb begin
        w_wr_ok   = 1'b0;
        w_wr_be   = 4'b0000;
        w_wr_data = ram_write_data;
        case (ram_write_mode)
            3'b000: begin
                w_wr_ok   = 1'b1;
                w_wr_be   = 4'b0001 << w_lane;
                w_wr_data = {4{ram_write_data[7:0]}};
            end
            3'b001: begin
                w_wr_ok   = !w_lane[0];
                w_wr_be   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{ram_write_data[15:0]}};
            end
            3'b010: begin
                w_wr_ok   = (w_lane == 2'b00);
                w_wr_be   = 4'b1111;
            end
            default: begin
                w_wr_ok   = 1'b0;
            end
        endcase
    end

    assign w_rd_word  = r_mem[w_idx];
    assign w_rd_shift = w_rd_word >> {w_lane, 3'b000};

    always_comb begin
        w_rd_ok  = 1'b0;
        w_rd_val = 32'd0;
        case (ram_read_mode)
            3'b000, 3'b100: begin
                w_rd_ok  = 1'b1;
                w_rd_val = {24'd0, w_rd_shift[7:0]};
            end
            3'b001, 3'b101: begin
                w_rd_ok  = !w_lane[0];
                w_rd_val = {16'd0, w_rd_shift[15:0]};
            end
            3'b010: begin
                w_rd_ok  = (w_lane == 2'b00);
                w_rd_val = w_rd_shift;
            end
            default: begin
                w_rd_ok  = 1'b0;
            end
        endcase
    end

    assign w_bad    = (w_is_wr && !w_wr_ok) || (w_is_rd && !w_rd_ok);
    assign w_rd_nxt = (w_is_rd && w_rd_ok) ? w_rd_val : 32'd0;

    // Array has no reset; contents survive reset_n.
    always_ff @(posedge clk) begin
        if (w_capture && w_is_wr && w_wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= 32'd0;
            r_mis     <= 1'b0;
        end else begin
            r_mis <= w_capture && w_bad;
            if (w_capture) begin
                r_rd_data <= w_rd_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_capture && w_access && (WAIT_CYCLES != 0)) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = WAIT4;
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    assign ram_wait      = (r_state == BUSY);
    assign misaligned    = r_mis;
    assign ram_read_data = r_rd_data;

endmodule
